// File: rtl/control_comandos_teclado.sv
// PS/2 scan-code sequencer: decodes make/break/extended prefixes, suppresses
// typematic repeat of the held key and queues 4-bit commands in a small FIFO.
module control_comandos_teclado #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    input  logic       cmd_ack,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [7:0] PFX_BRK = 8'hF0;
    localparam logic [7:0] PFX_EXT = 8'hE0;

    typedef enum logic [1:0] {ESPERA, RUPTURA, EXTENDIDO, EXT_RUPTURA} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [3:0]    held;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          make_ev, break_ev, is_pfx;
    logic [3:0]    code_cmd;
    logic          pop, push, full, wr_ok;

    function automatic logic [3:0] map_code(input logic [7:0] c);
        case (c)
            8'h05:   map_code = 4'd1;
            8'h06:   map_code = 4'd2;
            8'h04:   map_code = 4'd3;
            8'h0C:   map_code = 4'd4;
            8'h03:   map_code = 4'd5;
            8'h1D:   map_code = 4'd6;
            8'h1C:   map_code = 4'd7;
            8'h1B:   map_code = 4'd8;
            8'h23:   map_code = 4'd9;
            default: map_code = 4'd0;
        endcase
    endfunction

    assign is_pfx   = (code_in == PFX_BRK) || (code_in == PFX_EXT);
    assign code_cmd = map_code(code_in);

    always_ff @(posedge reloj) begin
        if (reset) state <= ESPERA;
        else       state <= next_state;
    end

    // A strobe in the timeout cycle is still decoded in the prefix state.
    always_comb begin
        next_state = state;
        if (code_valid) begin
            case (state)
                ESPERA:      if (code_in == PFX_BRK)      next_state = RUPTURA;
                             else if (code_in == PFX_EXT) next_state = EXTENDIDO;
                RUPTURA:     next_state = ESPERA;
                EXTENDIDO:   next_state = (code_in == PFX_BRK) ? EXT_RUPTURA : ESPERA;
                EXT_RUPTURA: next_state = ESPERA;
                default:     next_state = ESPERA;
            endcase
        end else if (state != ESPERA && cnt == CNT_MAX) begin
            next_state = ESPERA;
        end
    end

    always_comb begin
        make_ev  = 1'b0;
        break_ev = 1'b0;
        if (code_valid && !is_pfx) begin
            make_ev  = (state == ESPERA);
            break_ev = (state == RUPTURA);
        end
    end

    // Every prefix entry coincides with a strobe, so clearing on strobes suffices.
    always_ff @(posedge reloj) begin
        if (reset)               cnt <= '0;
        else if (code_valid)     cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = cmd_ack && (count != '0);
    assign push  = make_ev && (code_cmd != 4'd0) && (code_cmd != held);
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge reloj) begin
        if (reset) begin
            held     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                held <= code_cmd;
            else if (break_ev && code_cmd != 4'd0 && code_cmd == held)
                held <= '0;
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && !wr_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge reloj) begin
        if (wr_ok) mem[wr_ptr] <= code_cmd;
    end

    assign cmd_valid = (count != '0);
    assign cmd       = cmd_valid ? mem[rd_ptr] : 4'd0;
    assign fifo_full = full;

endmodule

// File: tb/tb_control_comandos_teclado.sv
// Directed plus random stimulus for control_comandos_teclado, checked against a
// queue-based model of prefixes, held key and command FIFO.
module tb_control_comandos_teclado;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       reloj = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic       cmd_ack = 1'b0;
    logic [3:0] cmd;
    logic       cmd_valid, fifo_full, overflow;

    always #5 reloj = ~reloj;

    control_comandos_teclado #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .reloj      (reloj),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .cmd_ack    (cmd_ack),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    // Reference model state
    logic [3:0] q[$];
    logic [7:0] pre[$];
    logic [3:0] m_held;
    bit         m_ovf;
    int         idle;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [3:0] lookup(input logic [7:0] c);
        logic [7:0] keys [9] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h1D, 8'h1C, 8'h1B, 8'h23};
        for (int i = 0; i < 9; i++)
            if (keys[i] == c) return 4'(i + 1);
        return 4'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("cmd",       {4'h0, cmd},       {4'h0, (q.size() != 0) ? q[0] : 4'h0});
        chk("cmd_valid", {7'h0, cmd_valid}, {7'h0, q.size() != 0});
        chk("fifo_full", {7'h0, fifo_full}, {7'h0, q.size() == DEPTH});
        chk("overflow",  {7'h0, overflow},  {7'h0, m_ovf});
    endtask

    task automatic model_make(input logic [7:0] c);
        logic [3:0] m;
        m = lookup(c);
        if (m != 0 && m != m_held) begin
            m_held = m;
            if (q.size() < DEPTH) q.push_back(m);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_edge(input logic v, input logic [7:0] c, input logic ack, input logic rst);
        if (rst) begin
            q.delete(); pre.delete();
            m_held = 0; m_ovf = 0; idle = 0;
            return;
        end
        if (ack && q.size() != 0) void'(q.pop_front());
        if (v) begin
            if (idle >= TIMEOUT) pre.delete();
            idle = 0;
            if (pre.size() == 0) begin
                if (c == 8'hF0 || c == 8'hE0) pre.push_back(c);
                else model_make(c);
            end else if (pre.size() == 1 && pre[0] == 8'hE0 && c == 8'hF0) begin
                pre.push_back(c);
            end else begin
                if (c != 8'hF0 && c != 8'hE0 && pre.size() == 1 && pre[0] == 8'hF0)
                    if (lookup(c) != 0 && lookup(c) == m_held) m_held = 0;
                pre.delete();
            end
        end else begin
            idle++;
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] c, input logic ack, input logic rst);
        code_valid = v; code_in = c; cmd_ack = ack; reset = rst;
        @(posedge reloj);
        model_edge(v, c, ack, rst);
        #1;
        check_all();
    endtask

    task automatic strobe(input logic [7:0] c);
        cycle(1'b1, c, 1'b0, 1'b0);
    endtask

    task automatic ack();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        m_held = 0; m_ovf = 0; idle = 0;
        do_reset();
        do_reset();
        chk("rst_cmd",   {4'h0, cmd},       8'h00);
        chk("rst_valid", {7'h0, cmd_valid}, 8'h00);
        chk("rst_full",  {7'h0, fifo_full}, 8'h00);
        chk("rst_ovf",   {7'h0, overflow},  8'h00);

        // Single make code, one-cycle latency, pop
        strobe(8'h1D);
        chk("t1_cmd",   {4'h0, cmd},       8'h06);
        chk("t1_valid", {7'h0, cmd_valid}, 8'h01);
        ack();
        chk("t1_empty", {7'h0, cmd_valid}, 8'h00);

        // Auto-repeat suppression, then release and press again
        repeat (5) strobe(8'h23);
        chk("t2_cmd", {4'h0, cmd}, 8'h09);
        ack();
        chk("t2_one", {7'h0, cmd_valid}, 8'h00);
        strobe(8'hF0); strobe(8'h23); strobe(8'h23);
        chk("t2_again", {4'h0, cmd}, 8'h09);
        ack();

        // Extended keys never produce commands
        strobe(8'hE0); strobe(8'h1C);
        chk("t3_ext", {7'h0, cmd_valid}, 8'h00);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h1C); strobe(8'h1C);
        chk("t3_cmd", {4'h0, cmd}, 8'h07);
        ack();

        // Fill and overflow
        strobe(8'h05); strobe(8'h06); strobe(8'h04); strobe(8'h0C); strobe(8'h03);
        chk("t4_full", {7'h0, fifo_full}, 8'h01);
        chk("t4_ovf",  {7'h0, overflow},  8'h01);
        for (int i = 1; i <= 4; i++) begin
            chk("t4_pop", {4'h0, cmd}, 8'(i));
            ack();
        end
        chk("t4_empty", {7'h0, cmd_valid}, 8'h00);
        chk("t4_sticky", {7'h0, overflow}, 8'h01);

        // Prefix timeout, then reset between prefix and code
        do_reset();
        strobe(8'hF0);
        repeat (TIMEOUT + 2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        strobe(8'h1B);
        chk("t5_tmo", {4'h0, cmd}, 8'h08);
        ack();
        strobe(8'hF0);
        do_reset();
        strobe(8'h1B);
        chk("t5_rst", {4'h0, cmd}, 8'h08);

        // Simultaneous push and pop while full
        do_reset();
        strobe(8'h05); strobe(8'h06); strobe(8'h04); strobe(8'h0C);
        chk("t6_full", {7'h0, fifo_full}, 8'h01);
        cycle(1'b1, 8'h1C, 1'b1, 1'b0);
        chk("t6_full2", {7'h0, fifo_full}, 8'h01);
        chk("t6_ovf",   {7'h0, overflow},  8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("t6_pop", {4'h0, cmd}, (i == 3) ? 8'h07 : 8'(i + 2));
            ack();
        end

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [7:0] pool [14] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h1D, 8'h1C,
                                     8'h1B, 8'h23, 8'hF0, 8'hF0, 8'hE0, 8'h00, 8'h55};
            logic [7:0] c;
            c = pool[$urandom_range(0, 13)];
            if ($urandom_range(0, 9) == 0) c = 8'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                    cycle(1'b0, 8'h00, 1'($urandom_range(0, 2) == 0), 1'b0);
            end
            cycle(1'($urandom_range(0, 2) != 0), c, 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 149) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
